// File: rtl/sr_pipe_ctrl_pkg.sv
// Shared types and constants for the schoolRISCV pipeline sequencer.
package sr_pipe_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    PCTL_RUN   = 2'd0,
    PCTL_STALL = 2'd1,
    PCTL_FLUSH = 2'd2
  } pctlState_e;

  // bge overrides the beq/bne zero-flag comparison.
  function automatic logic branchCond(input logic bge, input logic aluNeg,
                                      input logic aluZero, input logic condZero);
    return bge ? ~aluNeg : (aluZero == condZero);
  endfunction

endpackage

// File: rtl/sr_reg_scoreboard.sv
// Destination-register tracker for in-flight instructions plus RAW hit compare.
module sr_reg_scoreboard
  import sr_pipe_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wrEn,
  input  logic [4:0] wrRd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       useRs1,
  input  logic       useRs2,
  output logic       hit
);

  logic [PIPE_DEPTH-1:0] slotVld;
  logic [4:0]            slotRd [PIPE_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotVld <= '0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) slotRd[k] <= '0;
    end else begin
      slotVld[0] <= wrEn;
      slotRd[0]  <= wrRd;
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
        slotVld[k] <= slotVld[k-1];
        slotRd[k]  <= slotRd[k-1];
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      if (slotVld[k] &&
          ((useRs1 && rs1 != REG_ZERO && slotRd[k] == rs1) ||
           (useRs2 && rs2 != REG_ZERO && slotRd[k] == rs2)))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/sr_pipe_ctrl.sv
// Pipeline sequencer: RAW interlock, branch resolve/flush FSM and perf counters.
module sr_pipe_ctrl
  import sr_pipe_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned FLUSH_LEN  = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_regWrite_i,
  input  logic             ex_valid_i,
  input  logic             ex_branch_i,
  input  logic             ex_condZero_i,
  input  logic             ex_bge_i,
  input  logic             ex_aluZero_i,
  input  logic             ex_aluNeg_i,
  output logic             pc_src_o,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  pctlState_e       state, stateNext;
  logic [1:0]       flushCnt, flushCntNext;
  logic [CNT_W-1:0] stallTotal, flushTotal;
  logic             taken, kill, sbHit, hazard, stall, wrEn;

  assign taken  = ex_valid_i & ex_branch_i &
                  branchCond(ex_bge_i, ex_aluNeg_i, ex_aluZero_i, ex_condZero_i);
  assign kill   = taken | (state == PCTL_FLUSH);
  assign hazard = id_valid_i & ~kill & sbHit;
  assign stall  = hazard & ~taken;
  assign wrEn   = id_valid_i & id_regWrite_i & (id_rd_i != REG_ZERO) & ~stall & ~kill;

  sr_reg_scoreboard #(
    .PIPE_DEPTH(PIPE_DEPTH)
  ) uScoreboard (
    .clk   (clk),
    .rst_n (rst_n),
    .wrEn  (wrEn),
    .wrRd  (id_rd_i),
    .rs1   (id_rs1_i),
    .rs2   (id_rs2_i),
    .useRs1(id_use_rs1_i),
    .useRs2(id_use_rs2_i),
    .hit   (sbHit)
  );

  always_comb begin
    stateNext    = state;
    flushCntNext = flushCnt;
    if (taken) begin
      stateNext    = PCTL_FLUSH;
      flushCntNext = 2'(FLUSH_LEN - 1);
    end else begin
      case (state)
        PCTL_RUN:   if (hazard) stateNext = PCTL_STALL;
        PCTL_STALL: stateNext = hazard ? PCTL_STALL : PCTL_RUN;
        PCTL_FLUSH: begin
          if (flushCnt == 2'd0) stateNext = hazard ? PCTL_STALL : PCTL_RUN;
          else                  flushCntNext = flushCnt - 2'd1;
        end
        default:    stateNext = PCTL_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PCTL_RUN;
      flushCnt   <= '0;
      stallTotal <= '0;
      flushTotal <= '0;
    end else begin
      state    <= stateNext;
      flushCnt <= flushCntNext;
      if (stall && stallTotal != '1) stallTotal <= stallTotal + CNT_W'(1);
      if (taken && flushTotal != '1) flushTotal <= flushTotal + CNT_W'(1);
    end
  end

  // Comb outputs are held low for the whole reset assertion, not just at the edge.
  assign pc_src_o    = rst_n & taken;
  assign stall_o     = rst_n & stall;
  assign flush_o     = rst_n & kill;
  assign bubble_o    = rst_n & (stall | kill);
  assign stall_cnt_o = stallTotal;
  assign flush_cnt_o = flushTotal;

endmodule
